// File: rtl/rom_access_arbiter_if.sv
// Requester, ROM and status signals of the program-ROM arbiter.
// The addr_err member exists only when ROM_ACCESS_ARBITER_ADDR_ERR_EN is defined.
interface rom_access_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_gnt;
   logic              cpu_valid;
   logic [DATA_W-1:0] cpu_data;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_valid;
   logic [DATA_W-1:0] dbg_data;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              busy;
`ifdef ROM_ACCESS_ARBITER_ADDR_ERR_EN
   logic              addr_err;
`endif

   // Requesters and ROM side
   modport master (
      output cpu_req, cpu_addr, dbg_req, dbg_addr, rom_data,
      input  cpu_gnt, cpu_valid, cpu_data, dbg_gnt, dbg_valid, dbg_data,
             rom_addr, busy
`ifdef ROM_ACCESS_ARBITER_ADDR_ERR_EN
      , input addr_err
`endif
   );

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_addr, dbg_req, dbg_addr, rom_data,
      output cpu_gnt, cpu_valid, cpu_data, dbg_gnt, dbg_valid, dbg_data,
             rom_addr, busy
`ifdef ROM_ACCESS_ARBITER_ADDR_ERR_EN
      , output addr_err
`endif
   );
endinterface

// File: rtl/rom_access_arbiter.sv
// CPU/debug arbiter for the single-port synchronous program ROM (1-cycle read latency).
// Optional macro ROM_ACCESS_ARBITER_ADDR_ERR_EN: flag out-of-range reads and zero their data.
module rom_access_arbiter #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ROM_DEPTH = 128,
   parameter int unsigned MAX_WAIT  = 4
) (
   input logic                 clk,
   input logic                 reset,
   rom_access_arbiter_if.slave bus
);

   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

   owner_t            owner_q, owner_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] addr_hold_q, gnt_addr;
   logic              cpu_gnt_c, dbg_gnt_c, dbg_starved;
   logic [DATA_W-1:0] ret_data;

   assign dbg_starved = (32'(wait_cnt_q) >= MAX_WAIT);

   always_comb begin
      cpu_gnt_c  = 1'b0;
      dbg_gnt_c  = 1'b0;
      owner_d    = OWN_NONE;
      gnt_addr   = addr_hold_q;
      wait_cnt_d = '0;
      if (bus.cpu_req && !(bus.dbg_req && dbg_starved)) begin
         cpu_gnt_c = 1'b1;
         owner_d   = OWN_CPU;
         gnt_addr  = bus.cpu_addr;
      end else if (bus.dbg_req) begin
         dbg_gnt_c = 1'b1;
         owner_d   = OWN_DBG;
         gnt_addr  = bus.dbg_addr;
      end
      // Starvation counter saturates at 15 while debug is held off
      if (bus.dbg_req && !dbg_gnt_c)
         wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
   end

`ifdef ROM_ACCESS_ARBITER_ADDR_ERR_EN
   logic last_err_q;

   always_ff @(posedge clk) begin
      if (!reset)
         last_err_q <= 1'b0;
      else
         last_err_q <= (cpu_gnt_c || dbg_gnt_c) && (32'(gnt_addr) >= ROM_DEPTH);
   end

   assign ret_data     = last_err_q ? '0 : bus.rom_data;
   assign bus.addr_err = reset && (owner_q != OWN_NONE) && last_err_q;
`else
   assign ret_data = bus.rom_data;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         owner_q     <= OWN_NONE;
         wait_cnt_q  <= '0;
         addr_hold_q <= '0;
      end else begin
         owner_q     <= owner_d;
         wait_cnt_q  <= wait_cnt_d;
         addr_hold_q <= gnt_addr;
      end
   end

   // Outputs are gated by reset level so a read granted just before reset never returns
   assign bus.cpu_gnt   = reset && cpu_gnt_c;
   assign bus.dbg_gnt   = reset && dbg_gnt_c;
   assign bus.rom_addr  = reset ? gnt_addr : '0;
   assign bus.cpu_valid = reset && (owner_q == OWN_CPU);
   assign bus.dbg_valid = reset && (owner_q == OWN_DBG);
   assign bus.cpu_data  = bus.cpu_valid ? ret_data : '0;
   assign bus.dbg_data  = bus.dbg_valid ? ret_data : '0;
   assign bus.busy      = (owner_q != OWN_NONE);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: directed scenarios plus random traffic
// checked against a rule-level reference model and a behavioural 128x8 ROM.
module tb_rom_access_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  rom_access_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  rom_access_arbiter #(.ADDR_W(8), .DATA_W(8), .ROM_DEPTH(128), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural ROM: registered output, holds its value on out-of-range addresses
  logic [7:0] rom [0:127];
  always @(posedge clk) if (bus.rom_addr < 8'd128) bus.rom_data <= rom[bus.rom_addr[6:0]];

  // Reference model: grant decision from the arbitration rules
  function automatic int model_grant(input logic c, input logic d, input int w);
    if (c && !(d && w >= MAX_WAIT)) return 1;
    if (d) return 2;
    return 0;
  endfunction

  int         m_wait = 0;
  int         m_g;
  bit         m_vc = 0, m_vd = 0, m_err = 0;
  logic [7:0] m_pres = '0;
  logic [7:0] m_rom_out = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_wait = 0; m_vc = 0; m_vd = 0; m_err = 0; m_pres = '0;
    end else begin
      m_g  = model_grant(bus.cpu_req, bus.dbg_req, m_wait);
      m_vc = (m_g == 1);
      m_vd = (m_g == 2);
      if (m_g == 1) m_pres = bus.cpu_addr;
      else if (m_g == 2) m_pres = bus.dbg_addr;
      m_err  = (m_g != 0) && (m_pres >= 8'd128);
      m_wait = (bus.dbg_req && m_g != 2) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
    end
    if (m_pres < 8'd128) m_rom_out = rom[m_pres[6:0]];
  end

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    bus.cpu_addr = '0;  bus.dbg_addr = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.cpu_req = 1'($urandom); bus.dbg_req = 1'b1;
      bus.cpu_addr = 8'($urandom); bus.dbg_addr = 8'($urandom);
      #1;
      n_chk++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b exp=00", {bus.cpu_gnt, bus.dbg_gnt}); end
      n_chk++; if ({bus.cpu_valid, bus.dbg_valid} !== 2'b00) begin n_err++; $display("FAIL reset_valid got=%b exp=00", {bus.cpu_valid, bus.dbg_valid}); end
      n_chk++; if ({bus.cpu_data, bus.dbg_data, bus.rom_addr} !== 24'h0) begin n_err++; $display("FAIL reset_data_addr got=%h exp=000000", {bus.cpu_data, bus.dbg_data, bus.rom_addr}); end
    end
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_cpu_fetch();
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 8'd0; #1;
    n_chk++; if ({bus.cpu_gnt, bus.cpu_valid} !== 2'b10) begin n_err++; $display("FAIL fetch_c0 got=%b exp=10", {bus.cpu_gnt, bus.cpu_valid}); end
    @(negedge clk); bus.cpu_addr = 8'd2; #1;
    n_chk++; if ({bus.cpu_gnt, bus.cpu_valid} !== 2'b11) begin n_err++; $display("FAIL fetch_c1 got=%b exp=11", {bus.cpu_gnt, bus.cpu_valid}); end
    n_chk++; if (bus.cpu_data !== 8'h86) begin n_err++; $display("FAIL fetch_data0 got=%h exp=86", bus.cpu_data); end
    @(negedge clk); bus.cpu_req = 1'b0; #1;
    n_chk++; if ({bus.cpu_gnt, bus.cpu_valid} !== 2'b01) begin n_err++; $display("FAIL fetch_c2 got=%b exp=01", {bus.cpu_gnt, bus.cpu_valid}); end
    n_chk++; if (bus.cpu_data !== 8'h88) begin n_err++; $display("FAIL fetch_data1 got=%h exp=88", bus.cpu_data); end
    @(negedge clk); #1;
    n_chk++; if ({bus.cpu_valid, bus.busy, bus.cpu_data} !== 10'h0) begin n_err++; $display("FAIL fetch_idle got=%h exp=000", {bus.cpu_valid, bus.busy, bus.cpu_data}); end
  endtask

  task automatic test_starvation();
    int found = -1;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'd4;
    bus.dbg_req = 1'b1; bus.dbg_addr = 8'd11;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.dbg_gnt === 1'b1) begin found = i; break; end
      n_chk++; if (bus.cpu_gnt !== 1'b1) begin n_err++; $display("FAIL starve_cpu_gnt cycle=%0d got=%b exp=1", i, bus.cpu_gnt); end
      @(negedge clk);
    end
    n_chk++; if (found != MAX_WAIT) begin n_err++; $display("FAIL starve_dbg_cycle got=%0d exp=%0d", found, MAX_WAIT); end
    n_chk++; if (bus.cpu_gnt !== 1'b0) begin n_err++; $display("FAIL starve_exclusive got=%b exp=0", bus.cpu_gnt); end
    @(negedge clk); #1;
    n_chk++; if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b10) begin n_err++; $display("FAIL starve_cleared got=%b exp=10", {bus.cpu_gnt, bus.dbg_gnt}); end
    n_chk++; if ({bus.dbg_valid, bus.dbg_data, bus.cpu_valid} !== {1'b1, 8'h04, 1'b0}) begin n_err++; $display("FAIL starve_dbg_ret got=%h exp=%h", {bus.dbg_valid, bus.dbg_data, bus.cpu_valid}, {1'b1, 8'h04, 1'b0}); end
    @(negedge clk); idle_inputs(); #1;
    n_chk++; if ({bus.cpu_valid, bus.cpu_data} !== {1'b1, 8'h42}) begin n_err++; $display("FAIL starve_cpu_ret got=%h exp=142", {bus.cpu_valid, bus.cpu_data}); end
    @(negedge clk);
  endtask

  task automatic test_dbg_alone();
    int busy_cnt = 0;
    @(negedge clk); bus.dbg_req = 1'b1; bus.dbg_addr = 8'd3; #1;
    n_chk++; if ({bus.dbg_gnt, bus.cpu_gnt} !== 2'b10) begin n_err++; $display("FAIL dbg_alone_gnt got=%b exp=10", {bus.dbg_gnt, bus.cpu_gnt}); end
    busy_cnt += int'(bus.busy);
    @(negedge clk); bus.dbg_req = 1'b0; #1;
    n_chk++; if ({bus.dbg_valid, bus.dbg_data, bus.cpu_valid} !== {1'b1, 8'h01, 1'b0}) begin n_err++; $display("FAIL dbg_alone_ret got=%h exp=%h", {bus.dbg_valid, bus.dbg_data, bus.cpu_valid}, {1'b1, 8'h01, 1'b0}); end
    busy_cnt += int'(bus.busy);
    for (int i = 0; i < 3; i++) begin @(negedge clk); #1; busy_cnt += int'(bus.busy); end
    n_chk++; if (busy_cnt != 1) begin n_err++; $display("FAIL dbg_alone_busy_cycles got=%0d exp=1", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 8'd0;
    @(negedge clk); bus.cpu_req = 1'b0; bus.dbg_req = 1'b1; bus.dbg_addr = 8'd2; #1;
    n_chk++; if ({bus.cpu_valid, bus.cpu_data, bus.dbg_valid, bus.dbg_data} !== {1'b1, 8'h86, 1'b0, 8'h00}) begin n_err++; $display("FAIL b2b_r0 got=%h exp=%h", {bus.cpu_valid, bus.cpu_data, bus.dbg_valid, bus.dbg_data}, {1'b1, 8'h86, 1'b0, 8'h00}); end
    @(negedge clk); bus.dbg_req = 1'b0; bus.cpu_req = 1'b1; bus.cpu_addr = 8'd4; #1;
    n_chk++; if ({bus.cpu_valid, bus.cpu_data, bus.dbg_valid, bus.dbg_data} !== {1'b0, 8'h00, 1'b1, 8'h88}) begin n_err++; $display("FAIL b2b_r1 got=%h exp=%h", {bus.cpu_valid, bus.cpu_data, bus.dbg_valid, bus.dbg_data}, {1'b0, 8'h00, 1'b1, 8'h88}); end
    @(negedge clk); idle_inputs(); #1;
    n_chk++; if ({bus.cpu_valid, bus.cpu_data, bus.dbg_valid, bus.dbg_data} !== {1'b1, 8'h42, 1'b0, 8'h00}) begin n_err++; $display("FAIL b2b_r2 got=%h exp=%h", {bus.cpu_valid, bus.cpu_data, bus.dbg_valid, bus.dbg_data}, {1'b1, 8'h42, 1'b0, 8'h00}); end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 8'd0; #1;
    n_chk++; if (bus.cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rst_fly_gnt got=%b exp=1", bus.cpu_gnt); end
    @(negedge clk); bus.cpu_req = 1'b0; reset = 1'b0; #1;
    n_chk++; if ({bus.cpu_valid, bus.cpu_data} !== 9'h0) begin n_err++; $display("FAIL rst_fly_during got=%h exp=000", {bus.cpu_valid, bus.cpu_data}); end
    @(negedge clk); reset = 1'b1; #1;
    n_chk++; if ({bus.cpu_valid, bus.busy} !== 2'b00) begin n_err++; $display("FAIL rst_fly_after got=%b exp=00", {bus.cpu_valid, bus.busy}); end
    @(negedge clk); #1;
    n_chk++; if ({bus.cpu_valid, bus.busy} !== 2'b00) begin n_err++; $display("FAIL rst_fly_later got=%b exp=00", {bus.cpu_valid, bus.busy}); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 8'd4;
    @(negedge clk); bus.cpu_addr = 8'h90; #1;
    n_chk++; if ({bus.cpu_valid, bus.cpu_data} !== {1'b1, 8'h42}) begin n_err++; $display("FAIL oor_prev got=%h exp=142", {bus.cpu_valid, bus.cpu_data}); end
    @(negedge clk); bus.cpu_req = 1'b0; #1;
`ifdef ROM_ACCESS_ARBITER_ADDR_ERR_EN
    n_chk++; if ({bus.cpu_valid, bus.cpu_data, bus.addr_err} !== {1'b1, 8'h00, 1'b1}) begin n_err++; $display("FAIL oor_err got=%h exp=%h", {bus.cpu_valid, bus.cpu_data, bus.addr_err}, {1'b1, 8'h00, 1'b1}); end
    @(negedge clk); #1;
    n_chk++; if (bus.addr_err !== 1'b0) begin n_err++; $display("FAIL oor_err_pulse got=%b exp=0", bus.addr_err); end
`else
    n_chk++; if ({bus.cpu_valid, bus.cpu_data} !== {1'b1, 8'h42}) begin n_err++; $display("FAIL oor_stale got=%h exp=142", {bus.cpu_valid, bus.cpu_data}); end
    @(negedge clk);
`endif
  endtask

  task automatic test_random();
    int         g;
    logic [7:0] e_ra, e_ret;
    bit         e_ae;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.cpu_req  = ($urandom_range(0, 99) < 55);
      bus.dbg_req  = ($urandom_range(0, 99) < 45);
      bus.cpu_addr = 8'($urandom_range(0, 159));
      bus.dbg_addr = 8'($urandom_range(0, 159));
      #1;
      g     = model_grant(bus.cpu_req, bus.dbg_req, m_wait);
      e_ra  = (g == 1) ? bus.cpu_addr : (g == 2) ? bus.dbg_addr : m_pres;
      e_ret = m_rom_out;
      e_ae  = 1'b0;
`ifdef ROM_ACCESS_ARBITER_ADDR_ERR_EN
      if (m_err) e_ret = 8'h00;
      e_ae = (m_vc || m_vd) && m_err;
      n_chk++; if (bus.addr_err !== e_ae) begin n_err++; $display("FAIL rnd_addr_err cyc=%0d got=%b exp=%b", i, bus.addr_err, e_ae); end
`endif
      n_chk++; if ({bus.cpu_gnt, bus.dbg_gnt} !== {g == 1, g == 2}) begin n_err++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", i, {bus.cpu_gnt, bus.dbg_gnt}, {g == 1, g == 2}); end
      n_chk++; if (bus.rom_addr !== e_ra) begin n_err++; $display("FAIL rnd_rom_addr cyc=%0d got=%h exp=%h", i, bus.rom_addr, e_ra); end
      n_chk++; if ({bus.cpu_valid, bus.cpu_data} !== {m_vc, m_vc ? e_ret : 8'h00}) begin n_err++; $display("FAIL rnd_cpu_ret cyc=%0d got=%h exp=%h", i, {bus.cpu_valid, bus.cpu_data}, {m_vc, m_vc ? e_ret : 8'h00}); end
      n_chk++; if ({bus.dbg_valid, bus.dbg_data} !== {m_vd, m_vd ? e_ret : 8'h00}) begin n_err++; $display("FAIL rnd_dbg_ret cyc=%0d got=%h exp=%h", i, {bus.dbg_valid, bus.dbg_data}, {m_vd, m_vd ? e_ret : 8'h00}); end
      n_chk++; if (bus.busy !== (m_vc || m_vd)) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, bus.busy, m_vc || m_vd); end
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h86; rom[2] = 8'h88; rom[3] = 8'h01; rom[4] = 8'h42; rom[11] = 8'h04;
    idle_inputs();
    test_reset();
    test_cpu_fetch();
    test_starvation();
    test_dbg_alone();
    test_back_to_back();
    test_reset_inflight();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
